top_level_mult: RTL and testbench
=================================

Name: top_level_mult

Overview:
- Self-contained signed 8x8 multiply engine for program 2: a two-operand product C = A * B.
- Reads two 8-bit two's-complement operands from its internal data memory and computes the 16-bit two's-complement product.
- Writes the product back to data memory in little-endian order and signals completion.
- Sits at the top of the design and is driven only by clock, reset and a start/done handshake; operands and results are exchanged through the internal data memory.

Parameters:
- DM_DEPTH, 256, number of 8-bit words in the internal data memory.
- ADDR_A, 0, byte address of operand A.
- ADDR_B, 1, byte address of operand B.
- ADDR_LO, 2, byte address of product bits [7:0].
- ADDR_HI, 3, byte address of product bits [15:8].

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; a falling edge (1 to 0) starts one multiply.
- done  output  1  acknowledge; high when the product is in memory.

Behaviour:
- Internal data memory: instance named dm, storage array named core[0:DM_DEPTH-1] of 8 bits.
  - Must stay reachable by hierarchical reference (dm.core[i]) so benches can preload operands and read results directly.
  - Reset does not clear memory contents.
- Reset (reset=0, asynchronous): FSM to IDLE, done=0, operand/accumulator/counter registers cleared, start_q=1.
- Start detection: start is registered each clock into start_q. A falling edge is start_q==1 and start==0 at a rising clock edge, with the FSM in IDLE.
- FSM states, one clock each unless noted:
  - IDLE: done=0; a falling edge of start moves to LD_A.
  - LD_A: A <= core[ADDR_A].
  - LD_B: B <= core[ADDR_B].
  - MUL: 8 clocks of radix-2 signed shift-add (Booth or equivalent), with a 3-bit counter.
  - WR_LO: core[ADDR_LO] <= P[7:0].
  - WR_HI: core[ADDR_HI] <= P[15:8].
  - DONE: done=1.
- Latency: done rises exactly 13 rising clock edges after the edge that detected the start fall.
- done is registered (no glitches). It stays 1 in DONE until start is sampled high, then the FSM returns to IDLE and done=0 on that edge.
- Arithmetic:
  - Operands are interpreted as signed 8-bit values (range -128..127).
  - P = sign-extended A times sign-extended B, exact in 16 bits. Extremes: -128*-128 = 16384; -128*127 = -16256.
- Operand bytes core[ADDR_A] and core[ADDR_B] are never written by the engine. No other memory locations are written.
- Boundary conditions:
  - start held low after DONE: remain in DONE with done=1; no restart.
  - start falling while busy: ignored.
  - reset asserted mid-operation: immediate abort to IDLE, done=0. Memory keeps any bytes already written.
  - Operand 0 in either position: product 0x0000.
  - Back-to-back runs: each new start falling edge re-reads the operands, so operands updated between runs are honoured.

Test Plan:
- Preload core[0]=2, core[1]=0xFC (-4), release reset, drop start -> done after 13 clocks; core[3]=0xFF, core[2]=0xF8 (-8).
- core[0]=0, core[1]=0xFF -> {core[3],core[2]}=0x0000.
- core[0]=13, core[1]=7 -> 0x005B (91).
- core[0]=0xFF (-1), core[1]=3 -> 0xFFFD (-3).
- core[0]=99, core[1]=88 -> 0x2208 (8712).
- core[0]=0xC8 (-56), core[1]=0xC8 -> 0x0C40 (3136); then core[0]=core[1]=0x80 -> 0x4000. Also assert reset mid-MUL -> done=0, FSM idle, a subsequent run is correct.

Source files
------------

// File: rtl/top_level_mult.sv
`default_nettype none
// ============================================================================
// Module   : top_level_mult
// Purpose  : Self-contained signed 8x8 multiply engine. On a falling edge of
//            start it reads operand A and operand B from its internal data
//            memory and forms the 16-bit two's-complement product with an
//            8-step radix-2 shift-add. It then writes the product back
//            little-endian (low byte first) and raises done.
// Ports    : clk   - sole clock, rising edge
//            reset - asynchronous, active-low reset
//            start - request; a 1->0 transition starts one multiply
//            done  - registered acknowledge, high while the product is valid
// Revision : 1.0 - initial release
// ============================================================================
module top_level_mult #(
  parameter int DM_DEPTH = 256,
  parameter int ADDR_A   = 0,
  parameter int ADDR_B   = 1,
  parameter int ADDR_LO  = 2,
  parameter int ADDR_HI  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int c_AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

  localparam logic [c_AW-1:0] c_ADDR_A  = c_AW'(ADDR_A);
  localparam logic [c_AW-1:0] c_ADDR_B  = c_AW'(ADDR_B);
  localparam logic [c_AW-1:0] c_ADDR_LO = c_AW'(ADDR_LO);
  localparam logic [c_AW-1:0] c_ADDR_HI = c_AW'(ADDR_HI);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LD_A  = 3'd1,
    ST_LD_B  = 3'd2,
    ST_MUL   = 3'd3,
    ST_WR_LO = 3'd4,
    ST_WR_HI = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_start_q;
  logic              r_done;
  logic [15:0]       r_mcand;   // sign-extended A, shifted left each step
  logic [7:0]        r_mplier;  // B, shifted right each step
  logic [15:0]       r_acc;
  logic [2:0]        r_cnt;

  logic              w_fall;
  logic [c_AW-1:0]   w_rd_addr;
  logic [7:0]        w_rd_data;
  logic              w_we;
  logic [c_AW-1:0]   w_waddr;
  logic [7:0]        w_wdata;
  logic [15:0]       w_pp;

  // --------------------------------------------------------------------------
  // Internal data memory (kept as instance dm / array core for direct access)
  // --------------------------------------------------------------------------
  top_level_mult_dm #(
    .DEPTH (DM_DEPTH),
    .AW    (c_AW)
  ) dm (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  assign w_fall = r_start_q & ~start;

  // Partial product for the current multiplier bit. The MSB of a
  // two's-complement multiplier carries weight -2^7, so the last step
  // subtracts the shifted multiplicand instead of adding it.
  always_comb begin
    w_pp = 16'd0;
    if (r_mplier[0]) begin
      if (r_cnt == 3'd7) begin
        w_pp = ~r_mcand + 16'd1;
      end else begin
        w_pp = r_mcand;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and memory-port control
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_rd_addr    = c_ADDR_A;
    w_we         = 1'b0;
    w_waddr      = c_ADDR_LO;
    w_wdata      = 8'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_next_state = ST_LD_A;
        end
      end
      ST_LD_A: begin
        w_rd_addr    = c_ADDR_A;
        w_next_state = ST_LD_B;
      end
      ST_LD_B: begin
        w_rd_addr    = c_ADDR_B;
        w_next_state = ST_MUL;
      end
      ST_MUL: begin
        if (r_cnt == 3'd7) begin
          w_next_state = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        w_we         = 1'b1;
        w_waddr      = c_ADDR_LO;
        w_wdata      = r_acc[7:0];
        w_next_state = ST_WR_HI;
      end
      ST_WR_HI: begin
        w_we         = 1'b1;
        w_waddr      = c_ADDR_HI;
        w_wdata      = r_acc[15:8];
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        // Leave only once done has actually been presented for a cycle,
        // so a start that returned high early still yields a done pulse.
        if (r_done && start) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b1;
      r_done    <= 1'b0;
      r_mcand   <= 16'd0;
      r_mplier  <= 8'd0;
      r_acc     <= 16'd0;
      r_cnt     <= 3'd0;
    end else begin
      r_state   <= w_next_state;
      r_start_q <= start;
      // done is set on the first clock spent in DONE and cleared on the
      // same edge that returns the FSM to IDLE.
      r_done    <= (r_state == ST_DONE) && !(r_done && start);
      case (r_state)
        ST_LD_A: begin
          r_mcand <= {{8{w_rd_data[7]}}, w_rd_data};
          r_acc   <= 16'd0;
          r_cnt   <= 3'd0;
        end
        ST_LD_B: begin
          r_mplier <= w_rd_data;
        end
        ST_MUL: begin
          r_acc    <= r_acc + w_pp;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[7:1]};
          r_cnt    <= r_cnt + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign done = r_done;

endmodule

// ============================================================================
// Module   : top_level_mult_dm
// Purpose  : Byte-wide data memory with one combinational read port and one
//            synchronous write port. Contents are not affected by reset.
// Ports    : clk     - write clock
//            i_we    - write enable
//            i_waddr - write address
//            i_wdata - write data
//            i_raddr - read address
//            o_rdata - read data (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module top_level_mult_dm #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] core [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      core[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = core[i_raddr];

endmodule
`default_nettype wire

// File: tb/tb_top_level_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_level_mult
// Purpose  : Self-checking bench for top_level_mult. Operands are preloaded
//            into dm.core and results are read back from it. Expected
//            products come from signed integer multiplication.
// Revision : 1.0 - initial release
// ============================================================================
module tb_top_level_mult;

  logic clk;
  logic reset;
  logic start;
  logic done;

  int n_vec;
  int n_err;

  top_level_mult dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the exact signed product, truncated to 16 bits.
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // One complete multiply. Optionally glitches start while busy.
  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input bit glitch);
    int          edges;
    bit          seen;
    logic [15:0] exp;
    exp = ref_prod(a, b);
    @(negedge clk);
    dut.dm.core[0] = a;
    dut.dm.core[1] = b;
    dut.dm.core[2] = 8'hA5;
    dut.dm.core[3] = 8'h5A;
    dut.dm.core[4] = 8'h3C;
    start = 1'b0;
    edges = 0;
    seen  = 1'b0;
    // The first posedge detects the fall; done must rise 13 edges later.
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
      end else begin
        edges++;
      end
      if (glitch && i == 4) start = 1'b1;
      if (glitch && i == 5) start = 1'b0;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(edges), 32'd13);
    check("prod", {16'd0, dut.dm.core[3], dut.dm.core[2]}, {16'd0, exp});
    check("opA_kept", 32'(dut.dm.core[0]), 32'(a));
    check("opB_kept", 32'(dut.dm.core[1]), 32'(b));
    check("other_kept", 32'(dut.dm.core[4]), 32'h3C);
    // Holding start low keeps the engine parked in DONE.
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("done_clear", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  vec_t dir [8];

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b1;
    dir[0] = '{8'h02, 8'hFC};
    dir[1] = '{8'h00, 8'hFF};
    dir[2] = '{8'h0D, 8'h07};
    dir[3] = '{8'hFF, 8'h03};
    dir[4] = '{8'h63, 8'h58};
    dir[5] = '{8'hC8, 8'hC8};
    dir[6] = '{8'h80, 8'h80};
    dir[7] = '{8'h80, 8'h7F};

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_done", 32'(done), 32'd0);

    // Known products from the plan, including the signed extremes.
    check("ref_ex1", {16'd0, ref_prod(8'h80, 8'h80)}, 32'h4000);
    for (int i = 0; i < 8; i++) begin
      run_mult(dir[i].a, dir[i].b, 1'b0);
    end

    // Start re-dropped while busy must not disturb the run.
    run_mult(8'h0D, 8'h07, 1'b1);

    // Reset in the middle of MUL: abort, nothing written, then a clean run.
    @(negedge clk);
    dut.dm.core[0] = 8'h11;
    dut.dm.core[1] = 8'h22;
    dut.dm.core[2] = 8'hA5;
    dut.dm.core[3] = 8'h5A;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_done2", 32'(done), 32'd0);
    check("abort_mem", {16'd0, dut.dm.core[3], dut.dm.core[2]}, 32'h5AA5);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    run_mult(8'h11, 8'h22, 1'b0);

    // Randomized operands, back to back.
    for (int i = 0; i < 20; i++) begin
      run_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
